// File: rtl/ram_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding,
// requester indices and small helpers used by the arbitration logic.
package ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_idx_e;

  // Wide enough for MAX_BURST up to 15.
  localparam int unsigned CNT_W = 4;

  function automatic req_idx_e other_side(input req_idx_e s);
    return (s == REQ_A) ? REQ_B : REQ_A;
  endfunction

  function automatic arb_state_e own_state(input req_idx_e s);
    return (s == REQ_A) ? ST_OWN_A : ST_OWN_B;
  endfunction

endpackage

// File: rtl/single_port_ram.sv
// Single-port RAM: synchronous write, asynchronous read of the addressed word.
// Contents are not reset.
module single_port_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of one single-port RAM: round-robin with
// optional bounded lock bursts, one access per cycle, registered read return.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int veriGenisligi   = 8,
  parameter int addresGenisligi = 10,
  parameter int MAX_BURST       = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       req_a,
  input  logic                       req_b,
  input  logic                       lock_a,
  input  logic                       lock_b,
  input  logic                       we_a,
  input  logic                       we_b,
  input  logic [addresGenisligi-1:0] addr_a,
  input  logic [addresGenisligi-1:0] addr_b,
  input  logic [veriGenisligi-1:0]   wdata_a,
  input  logic [veriGenisligi-1:0]   wdata_b,
  output logic                       gnt_a,
  output logic                       gnt_b,
  output logic                       rvalid_a,
  output logic                       rvalid_b,
  output logic [veriGenisligi-1:0]   rdata,
  output logic                       busy
);

  arb_state_e                 r_state;
  req_idx_e                   r_prio;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_run;
  logic                       r_rvalid_a;
  logic                       r_rvalid_b;
  logic [veriGenisligi-1:0]   r_rdata;
  logic                       r_busy;

  arb_state_e                 w_state_nxt;
  req_idx_e                   w_prio_nxt;
  logic [CNT_W-1:0]           w_cnt_nxt;
  logic [1:0]                 w_req;
  logic [1:0]                 w_lock;
  logic [1:0]                 w_gnt;
  req_idx_e                   w_win;
  req_idx_e                   w_own;
  req_idx_e                   w_oth;
  logic                       w_below_max;

  req_idx_e                   w_sel;
  logic                       w_sel_we;
  logic                       w_ram_we;
  logic                       w_rd_en;
  logic [addresGenisligi-1:0] w_ram_addr;
  logic [veriGenisligi-1:0]   w_ram_wdata;
  logic [veriGenisligi-1:0]   w_ram_rdata;

  assign w_req       = {req_b, req_a};
  assign w_lock      = {lock_b, lock_a};
  assign w_below_max = (r_cnt < CNT_W'(MAX_BURST));

  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_cnt_nxt   = r_cnt;
    w_gnt       = '0;
    w_win       = REQ_A;
    w_own       = REQ_A;
    w_oth       = REQ_B;
    // r_run holds grants off for one cycle after reset release.
    if (r_run) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_req != '0) begin
            w_win        = (w_req == 2'b11) ? r_prio : (w_req[REQ_A] ? REQ_A : REQ_B);
            w_gnt[w_win] = 1'b1;
            w_state_nxt  = own_state(w_win);
            w_cnt_nxt    = CNT_W'(1);
          end
        end
        ST_OWN_A, ST_OWN_B: begin
          w_own = (r_state == ST_OWN_A) ? REQ_A : REQ_B;
          w_oth = other_side(w_own);
          if (w_req[w_own] && (!w_req[w_oth] || (w_lock[w_own] && w_below_max))) begin
            w_gnt[w_own] = 1'b1;
            if (w_below_max) w_cnt_nxt = r_cnt + CNT_W'(1);
          end else if (w_req[w_oth]) begin
            w_gnt[w_oth] = 1'b1;
            w_state_nxt  = own_state(w_oth);
            w_cnt_nxt    = CNT_W'(1);
            w_prio_nxt   = w_own;
          end else begin
            w_state_nxt  = ST_IDLE;
            w_prio_nxt   = w_oth;
            w_cnt_nxt    = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign w_sel       = w_gnt[REQ_B] ? REQ_B : REQ_A;
  assign w_sel_we    = (w_sel == REQ_B) ? we_b : we_a;
  assign w_ram_addr  = (w_sel == REQ_B) ? addr_b : addr_a;
  assign w_ram_wdata = (w_sel == REQ_B) ? wdata_b : wdata_a;
  assign w_ram_we    = (|w_gnt) & w_sel_we;
  assign w_rd_en     = (|w_gnt) & ~w_sel_we;

  single_port_ram #(
    .DATA_W (veriGenisligi),
    .ADDR_W (addresGenisligi)
  ) u_ram (
    .i_clk   (clock),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_run      <= 1'b0;
      r_state    <= ST_IDLE;
      r_prio     <= REQ_A;
      r_cnt      <= '0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_state    <= w_state_nxt;
      r_prio     <= w_prio_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rvalid_a <= w_gnt[REQ_A] & ~we_a;
      r_rvalid_b <= w_gnt[REQ_B] & ~we_b;
      if (w_rd_en) r_rdata <= w_ram_rdata;
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

  assign gnt_a    = w_gnt[REQ_A];
  assign gnt_b    = w_gnt[REQ_B];
  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;
  assign rdata    = r_rdata;
  assign busy     = r_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the arbitration rules.
module tb_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int MB = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_a = 1'b0, req_b = 1'b0;
  logic          lock_a = 1'b0, lock_b = 1'b0;
  logic          we_a = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
  logic [DW-1:0] rdata;

  ram_arbiter #(
    .veriGenisligi   (DW),
    .addresGenisligi (AW),
    .MAX_BURST       (MB)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_a    (req_a),
    .req_b    (req_b),
    .lock_a   (lock_a),
    .lock_b   (lock_b),
    .we_a     (we_a),
    .we_b     (we_b),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .wdata_a  (wdata_a),
    .wdata_b  (wdata_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .rvalid_a (rvalid_a),
    .rvalid_b (rvalid_b),
    .rdata    (rdata),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: owner 0 = none, 1 = A, 2 = B; prio 1 = A, 2 = B.
  logic [DW-1:0] m_mem   [0:(1<<AW)-1];
  bit            m_known [0:(1<<AW)-1];
  int            m_owner, m_prio, m_cnt;
  bit            m_run, m_rva, m_rvb, m_rdata_known;
  logic [DW-1:0] m_rdata;
  bit            e_ga, e_gb;
  int            n_owner, n_prio, n_cnt;
  bit            last_ga, last_gb;
  string         seq;

  task automatic model_reset();
    m_owner = 0; m_prio = 1; m_cnt = 0; m_run = 0;
    m_rva = 0; m_rvb = 0; m_rdata = '0; m_rdata_known = 1;
  endtask

  task automatic model_eval();
    int win, other;
    bit rx, ry, lx;
    e_ga = 0; e_gb = 0; win = 0;
    n_owner = m_owner; n_prio = m_prio; n_cnt = m_cnt;
    if (m_run) begin
      if (m_owner == 0) begin
        if (req_a && req_b) win = m_prio;
        else if (req_a)     win = 1;
        else if (req_b)     win = 2;
        if (win != 0) begin n_owner = win; n_cnt = 1; end
      end else begin
        other = 3 - m_owner;
        rx = (m_owner == 1) ? req_a  : req_b;
        ry = (m_owner == 1) ? req_b  : req_a;
        lx = (m_owner == 1) ? lock_a : lock_b;
        if (rx && (!ry || (lx && m_cnt < MB))) begin
          win = m_owner;
          if (m_cnt < MB) n_cnt = m_cnt + 1;
        end else if (ry) begin
          win = other; n_owner = other; n_cnt = 1; n_prio = m_owner;
        end else begin
          n_owner = 0; n_prio = other; n_cnt = 0;
        end
      end
    end
    e_ga = (win == 1);
    e_gb = (win == 2);
  endtask

  task automatic model_commit();
    if (e_ga) begin
      if (we_a) begin m_mem[addr_a] = wdata_a; m_known[addr_a] = 1; end
      else begin m_rdata = m_mem[addr_a]; m_rdata_known = m_known[addr_a]; end
    end
    if (e_gb) begin
      if (we_b) begin m_mem[addr_b] = wdata_b; m_known[addr_b] = 1; end
      else begin m_rdata = m_mem[addr_b]; m_rdata_known = m_known[addr_b]; end
    end
    m_rva = e_ga && !we_a;
    m_rvb = e_gb && !we_b;
    m_owner = n_owner; m_prio = n_prio; m_cnt = n_cnt;
    m_run = 1;
  endtask

  // One clock cycle: inputs already driven at the preceding falling edge.
  task automatic step();
    #1;
    model_eval();
    chk("gnt_a", gnt_a, e_ga);
    chk("gnt_b", gnt_b, e_gb);
    chk("one_grant", gnt_a & gnt_b, 0);
    chk("rvalid_a", rvalid_a, m_rva);
    chk("rvalid_b", rvalid_b, m_rvb);
    chk("busy", busy, m_owner != 0);
    if (m_rdata_known) chk("rdata", rdata, m_rdata);
    last_ga = gnt_a;
    last_gb = gnt_b;
    seq = {seq, gnt_a ? "A" : (gnt_b ? "B" : "-")};
    @(posedge clock);
    if (reset_n) model_commit();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    req_a = 0; req_b = 0; lock_a = 0; lock_b = 0; we_a = 0; we_b = 0;
  endtask

  task automatic check_seq(input string tag, input string exp);
    for (int i = 0; i < exp.len(); i++)
      chk($sformatf("%s_%0d", tag, i), seq[i], exp[i]);
  endtask

  initial begin
    string exp;
    int wait_a, wait_b;
    bit pend_a, pend_b;
    for (int i = 0; i < (1<<AW); i++) m_known[i] = 0;
    model_reset();

    // Reset state, with a request present to show grants are held off.
    @(negedge clock);
    req_a = 1;
    #1;
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_rvalid_a", rvalid_a, 0);
    chk("rst_rvalid_b", rvalid_b, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    @(negedge clock);
    req_a = 0;
    reset_n = 1;
    step();

    // Both reading without lock: alternate A,B,...
    seq = "";
    req_a = 1; req_b = 1; addr_a = 10'd3; addr_b = 10'd7;
    repeat (6) step();
    exp = "ABABAB";
    check_seq("alt", exp);
    idle_inputs();
    step();

    // A writes 0xA5 to 3, then reads it back.
    req_a = 1; we_a = 1; addr_a = 10'd3; wdata_a = 8'hA5;
    step();
    chk("wr3_gnt", last_ga, 1);
    we_a = 0;
    step();
    chk("rd3_gnt", last_ga, 1);
    chk("rd3_rvalid", rvalid_a, 1);
    chk("rd3_rdata", rdata, 8'hA5);
    idle_inputs();
    step();
    chk("rd3_rvalid_drop", rvalid_a, 0);

    // B writes 0x3C to 7, A reads 7 on the very next cycle.
    req_b = 1; we_b = 1; addr_b = 10'd7; wdata_b = 8'h3C;
    step();
    chk("wr7_gnt", last_gb, 1);
    req_b = 0; we_b = 0; req_a = 1; addr_a = 10'd7;
    step();
    chk("rd7_gnt", last_ga, 1);
    chk("rd7_rvalid", rvalid_a, 1);
    chk("rd7_rdata", rdata, 8'h3C);
    idle_inputs();
    step();

    // A locked write burst, reset lands while A still has a write to 3 pending.
    req_a = 1; lock_a = 1; we_a = 1;
    for (int i = 0; i < 3; i++) begin
      addr_a = AW'(20 + i); wdata_a = DW'(8'h50 + i);
      step();
    end
    chk("pre_rst_busy", busy, 1);
    addr_a = 10'd3; wdata_a = 8'h77;
    reset_n = 0;
    model_reset();
    #1;
    chk("midrst_gnt_a", gnt_a, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rvalid", rvalid_a, 0);
    chk("midrst_rdata", rdata, 0);
    step();
    reset_n = 1;
    req_b = 1; we_a = 0; we_b = 0; addr_a = 10'd3; addr_b = 10'd7;
    step();
    chk("sync_no_gnt", last_ga | last_gb, 0);

    // Locked burst of A while B waits: 4 grants to A, then B, then A again.
    seq = "";
    step();
    chk("post_rst_rd3", rdata, 8'hA5);
    repeat (7) step();
    exp = "AAAABAAA";
    check_seq("burst", exp);
    idle_inputs();
    step();

    // Randomized traffic over a small address window.
    pend_a = 0; pend_b = 0; wait_a = 0; wait_b = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!pend_a && $urandom_range(0, 99) < 60) begin
        pend_a = 1; we_a = $urandom_range(0, 1);
        addr_a = AW'($urandom_range(0, 15)); wdata_a = DW'($urandom);
      end else if (pend_a && $urandom_range(0, 99) < 2) pend_a = 0;
      if (!pend_b && $urandom_range(0, 99) < 60) begin
        pend_b = 1; we_b = $urandom_range(0, 1);
        addr_b = AW'($urandom_range(0, 15)); wdata_b = DW'($urandom);
      end else if (pend_b && $urandom_range(0, 99) < 2) pend_b = 0;
      req_a = pend_a; req_b = pend_b;
      lock_a = ($urandom_range(0, 3) != 0);
      lock_b = ($urandom_range(0, 3) != 0);
      step();
      wait_a = (req_a && !last_ga) ? wait_a + 1 : 0;
      wait_b = (req_b && !last_gb) ? wait_b + 1 : 0;
      chk("starve_a", wait_a <= MB + 1, 1);
      chk("starve_b", wait_b <= MB + 1, 1);
      if (last_ga) pend_a = 0;
      if (last_gb) pend_b = 0;
    end
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter veriGenisligi, default 8, data word width in bits.
REQ-002 SHALL have parameter addresGenisligi, default 10, address width in bits (depth 2**addresGenisligi).
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum consecutive grants to a locked owner while the other requester waits (legal range 1..15).
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 req_a / req_b  input  1  access request from requester A / B, held until granted.
REQ-007 lock_a / lock_b  input  1  requester asks to keep ownership for back-to-back accesses.
REQ-008 we_a / we_b  input  1  1 = write, 0 = read; qualified by request.
REQ-009 addr_a / addr_b  input  addresGenisligi  access address.
REQ-010 wdata_a / wdata_b  input  veriGenisligi  write data.
REQ-011 gnt_a / gnt_b  output  1  combinational; access performed at the coming rising edge.
REQ-012 rvalid_a / rvalid_b  output  1  registered; rdata holds read result for that requester.
REQ-013 rdata  output  veriGenisligi  registered read data, shared by both requesters.
REQ-014 busy  output  1  registered; 1 when state is not IDLE.

Function
REQ-015 SHALL perform at most one RAM access per cycle; gnt_a and gnt_b SHALL never both be 1.
REQ-016 SHALL implement FSM states IDLE, OWN_A, OWN_B, plus a priority pointer prio (A or B) and a saturating grant counter cnt (0..MAX_BURST).
REQ-017 IDLE: no request -> stay IDLE, no grant; one request -> grant it; both -> grant prio; granted side becomes owner, cnt=1.
REQ-018 OWN_x: grant x again iff req_x and (not req_y, or (lock_x and cnt<MAX_BURST)); cnt increments, saturating.
REQ-019 OWN_x otherwise, if req_y: grant y, move to OWN_y, cnt=1, prio=x.
REQ-020 OWN_x with no request: no grant, move to IDLE, prio = the side that was not the owner.
REQ-021 Write grant: RAM word at the granted addr SHALL take the granted wdata at the same rising edge; rvalid stays 0.
REQ-022 Read grant: rdata SHALL take RAM[addr] at the same rising edge, and the matching rvalid is 1 for exactly the following cycle (latency 1).
REQ-023 rdata SHALL hold its last value when no read is granted.
REQ-024 A read granted the cycle after a write to the same address SHALL return the newly written data.
REQ-025 lock with no request SHALL have no effect; lock_y SHALL not prevent switching away from owner x.
REQ-026 Requester whose req drops before grant SHALL receive nothing; no request queueing.

Reset
REQ-027 reset_n low SHALL immediately force state IDLE, prio A, cnt 0, rvalid_a/rvalid_b 0, rdata 0, busy 0.
REQ-028 gnt_a/gnt_b SHALL be 0 while reset_n is low.
REQ-029 RAM contents SHALL not be cleared by reset; reset during a granted access SHALL abort that access.
REQ-030 Release of reset SHALL be synchronous to clock before first grant is honored (one sync stage allowed, documented latency fixed at 0 or 1 cycle).

Structure
REQ-031 State encoding and requester-index constants SHALL reside in the shared package ram_pkg.
REQ-032 Storage SHALL be one instance of single_port_ram, with its address, write enable and write data driven by a grant mux.
REQ-033 Arbitration logic SHALL be in ram_arbiter itself; no further sub-modules.

Verification
REQ-034 After reset, A writes 0xA5 to addr 3, then A reads addr 3 -> gnt_a each cycle, rvalid_a=1 with rdata=0xA5 one cycle after read grant.
REQ-035 req_a and req_b both high from IDLE, no lock, both reading -> grants alternate A,B,A,B; rvalid matches each grant one cycle later.
REQ-036 lock_a high, req_a and req_b high, MAX_BURST=4 -> exactly 4 gnt_a, then gnt_b, then back to A.
REQ-037 B writes 0x3C to addr 7; next cycle A reads addr 7 -> rdata=0x3C with rvalid_a.
REQ-038 reset_n pulsed low mid-burst of A -> gnt, rvalid, busy go 0 immediately; after release, both requesting -> A granted first; previously written words still readable.
REQ-039 Random req/lock/we over 10000 cycles against a reference model -> no dual grant, no starvation beyond MAX_BURST+1 cycles, all read data matches.
